// File: rtl/pipe_pkg.sv
// Shared pipeline constants: bundle widths, ALU one-hot bit positions and
// LA32R opcode fields decoded by the ID stage.
package pipe_pkg;

    localparam int ID_BUS_W = 64;
    localparam int EX_BUS_W = 148;
    localparam int WB_BUS_W = 38;
    localparam int BR_BUS_W = 33;

    localparam int ALU_OP_W = 12;
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    // Matched against inst[31:15]
    localparam logic [16:0] OP_ADD_W  = 17'h00020;
    localparam logic [16:0] OP_SUB_W  = 17'h00022;
    localparam logic [16:0] OP_SLT    = 17'h00024;
    localparam logic [16:0] OP_SLTU   = 17'h00025;
    localparam logic [16:0] OP_NOR    = 17'h00028;
    localparam logic [16:0] OP_AND    = 17'h00029;
    localparam logic [16:0] OP_OR     = 17'h0002a;
    localparam logic [16:0] OP_XOR    = 17'h0002b;
    localparam logic [16:0] OP_SLLI_W = 17'h00081;
    localparam logic [16:0] OP_SRLI_W = 17'h00089;
    localparam logic [16:0] OP_SRAI_W = 17'h00091;

    // Matched against inst[31:22]
    localparam logic [9:0] OP_ADDI_W = 10'h00a;
    localparam logic [9:0] OP_LD_W   = 10'h0a2;
    localparam logic [9:0] OP_ST_W   = 10'h0a6;

    // Matched against inst[31:25]
    localparam logic [6:0] OP_LU12I_W = 7'h0a;

    // Matched against inst[31:26]
    localparam logic [5:0] OP_JIRL = 6'h13;
    localparam logic [5:0] OP_B    = 6'h14;
    localparam logic [5:0] OP_BL   = 6'h15;
    localparam logic [5:0] OP_BEQ  = 6'h16;
    localparam logic [5:0] OP_BNE  = 6'h17;

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, r0 reads as zero. Contents are deliberately not reset.
module regfile (
    input  logic        clk,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] mem_q [32];

    always_ff @(posedge clk) begin
        if (we && (waddr != 5'd0)) begin
            mem_q[waddr] <= wdata;
        end
    end

    // No write-to-read bypass; the dest-based hazard check stalls instead.
    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : mem_q[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : mem_q[raddr2];

endmodule

// File: rtl/id_stage.sv
// Decode stage: latches the IF bundle, decodes the LA32R subset, reads the
// register file, resolves branches and stalls on pending destinations.
module id_stage
    import pipe_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                IDsignal_valid,
    input  logic [ID_BUS_W-1:0] ID_signal,
    input  logic                EX_allowin,
    input  logic [WB_BUS_W-1:0] WB_rf_bus,
    input  logic [4:0]          EX_dest,
    input  logic [4:0]          MEM_dest,
    input  logic [4:0]          WB_dest,
    output logic                ID_allowin,
    output logic [BR_BUS_W-1:0] br_signal,
    output logic                EXsignal_valid,
    output logic [EX_BUS_W-1:0] EX_signal
);

    // Handshake: a bundle moves across a boundary on a clock edge where the
    // producer's valid and the consumer's allowin are both high; the producer
    // holds its bundle unchanged while valid is high and allowin is low.

    logic                id_valid_q, id_valid_d;
    logic [ID_BUS_W-1:0] id_signal_q, id_signal_d;
    logic                id_readygo;
    logic                hazard;

    logic [31:0] inst, pc;
    logic [4:0]  rd, rj, rk;
    logic [16:0] op_31_15;
    logic inst_add, inst_sub, inst_slt, inst_sltu, inst_nor, inst_and;
    logic inst_or, inst_xor, inst_slli, inst_srli, inst_srai, inst_addi;
    logic inst_lu12i, inst_ld, inst_st, inst_jirl, inst_b, inst_bl;
    logic inst_beq, inst_bne;
    logic is_3r, is_shift, use_rj, use_rk, use_rd;

    logic [31:0] imm_si12, imm_ui5, imm_lu, br_offs;
    logic [31:0] rj_value, rd2_value;
    logic [31:0] src1, src2, br_target;
    logic [ALU_OP_W-1:0] alu_op;
    logic [4:0]  dest;
    logic        gr_we_raw, gr_we, br_taken;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    assign {rf_we, rf_waddr, rf_wdata} = WB_rf_bus;

    assign inst     = id_signal_q[63:32];
    assign pc       = id_signal_q[31:0];
    assign rd       = inst[4:0];
    assign rj       = inst[9:5];
    assign rk       = inst[14:10];
    assign op_31_15 = inst[31:15];

    assign inst_add   = (op_31_15 == OP_ADD_W);
    assign inst_sub   = (op_31_15 == OP_SUB_W);
    assign inst_slt   = (op_31_15 == OP_SLT);
    assign inst_sltu  = (op_31_15 == OP_SLTU);
    assign inst_nor   = (op_31_15 == OP_NOR);
    assign inst_and   = (op_31_15 == OP_AND);
    assign inst_or    = (op_31_15 == OP_OR);
    assign inst_xor   = (op_31_15 == OP_XOR);
    assign inst_slli  = (op_31_15 == OP_SLLI_W);
    assign inst_srli  = (op_31_15 == OP_SRLI_W);
    assign inst_srai  = (op_31_15 == OP_SRAI_W);
    assign inst_addi  = (inst[31:22] == OP_ADDI_W);
    assign inst_ld    = (inst[31:22] == OP_LD_W);
    assign inst_st    = (inst[31:22] == OP_ST_W);
    assign inst_lu12i = (inst[31:25] == OP_LU12I_W);
    assign inst_jirl  = (inst[31:26] == OP_JIRL);
    assign inst_b     = (inst[31:26] == OP_B);
    assign inst_bl    = (inst[31:26] == OP_BL);
    assign inst_beq   = (inst[31:26] == OP_BEQ);
    assign inst_bne   = (inst[31:26] == OP_BNE);

    assign is_3r    = inst_add | inst_sub | inst_slt | inst_sltu | inst_nor
                    | inst_and | inst_or | inst_xor;
    assign is_shift = inst_slli | inst_srli | inst_srai;
    assign use_rj   = is_3r | is_shift | inst_addi | inst_ld | inst_st
                    | inst_jirl | inst_beq | inst_bne;
    assign use_rk   = is_3r;
    assign use_rd   = inst_st | inst_beq | inst_bne;

    assign imm_si12 = {{20{inst[21]}}, inst[21:10]};
    assign imm_ui5  = {27'd0, inst[14:10]};
    assign imm_lu   = {inst[24:5], 12'd0};
    assign br_offs  = (inst_b | inst_bl)
                    ? {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00}
                    : {{14{inst[25]}}, inst[25:10], 2'b00};

    // Second read port serves rd for store data / branch compare, rk otherwise.
    regfile u_regfile (
        .clk    (clk),
        .raddr1 (rj),
        .rdata1 (rj_value),
        .raddr2 (use_rd ? rd : rk),
        .rdata2 (rd2_value),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata)
    );

    function automatic logic pending(input logic [4:0] a, input logic [4:0] d0,
                                     input logic [4:0] d1, input logic [4:0] d2);
        return (a != 5'd0) && ((a == d0) || (a == d1) || (a == d2));
    endfunction

    assign hazard = (use_rj && pending(rj, EX_dest, MEM_dest, WB_dest))
                  | (use_rk && pending(rk, EX_dest, MEM_dest, WB_dest))
                  | (use_rd && pending(rd, EX_dest, MEM_dest, WB_dest));

    assign id_readygo     = !(id_valid_q && hazard);
    assign ID_allowin     = !id_valid_q || (id_readygo && EX_allowin);
    assign EXsignal_valid = id_valid_q && id_readygo;

    always_comb begin
        alu_op = '0;
        alu_op[ALU_ADD]  = inst_add | inst_addi | inst_ld | inst_st | inst_jirl | inst_bl;
        alu_op[ALU_SUB]  = inst_sub;
        alu_op[ALU_SLT]  = inst_slt;
        alu_op[ALU_SLTU] = inst_sltu;
        alu_op[ALU_AND]  = inst_and;
        alu_op[ALU_NOR]  = inst_nor;
        alu_op[ALU_OR]   = inst_or;
        alu_op[ALU_XOR]  = inst_xor;
        alu_op[ALU_SLL]  = inst_slli;
        alu_op[ALU_SRL]  = inst_srli;
        alu_op[ALU_SRA]  = inst_srai;
        alu_op[ALU_LUI]  = inst_lu12i;
    end

    always_comb begin
        src1 = (inst_bl | inst_jirl) ? pc : rj_value;
        src2 = rd2_value;
        if (inst_bl | inst_jirl) begin
            src2 = 32'd4;
        end else if (inst_addi | inst_ld | inst_st) begin
            src2 = imm_si12;
        end else if (is_shift) begin
            src2 = imm_ui5;
        end else if (inst_lu12i) begin
            src2 = imm_lu;
        end
    end

    assign dest      = inst_bl ? 5'd1 : rd;
    assign gr_we_raw = is_3r | is_shift | inst_addi | inst_lu12i | inst_ld
                     | inst_jirl | inst_bl;
    assign gr_we     = gr_we_raw && (dest != 5'd0);

    assign br_taken  = id_valid_q && id_readygo
                     && (inst_b | inst_bl | inst_jirl
                         | (inst_beq && (rj_value == rd2_value))
                         | (inst_bne && (rj_value != rd2_value)));
    assign br_target = (inst_jirl ? rj_value : pc) + br_offs;
    assign br_signal = {br_taken, br_taken ? br_target : 32'd0};

    assign EX_signal = {alu_op, src1, src2, rd2_value, dest, gr_we,
                        inst_st, inst_ld, pc};

    always_comb begin
        id_valid_d  = id_valid_q;
        id_signal_d = id_signal_q;
        if (ID_allowin) begin
            id_valid_d = IDsignal_valid;
            if (IDsignal_valid) begin
                id_signal_d = ID_signal;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid_q  <= 1'b0;
            id_signal_q <= '0;
        end else begin
            id_valid_q  <= id_valid_d;
            id_signal_q <= id_signal_d;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: inputs change 1ns after the rising edge and
// outputs are checked 2-3ns after it, well clear of the next edge.
module tb_id_stage;

  logic         clk;
  logic         reset;
  logic         IDsignal_valid;
  logic [63:0]  ID_signal;
  logic         EX_allowin;
  logic [37:0]  WB_rf_bus;
  logic [4:0]   EX_dest, MEM_dest, WB_dest;
  logic         ID_allowin;
  logic [32:0]  br_signal;
  logic         EXsignal_valid;
  logic [147:0] EX_signal;

  int tests_run;
  int tests_failed;

  id_stage dut (
    .clk            (clk),
    .reset          (reset),
    .IDsignal_valid (IDsignal_valid),
    .ID_signal      (ID_signal),
    .EX_allowin     (EX_allowin),
    .WB_rf_bus      (WB_rf_bus),
    .EX_dest        (EX_dest),
    .MEM_dest       (MEM_dest),
    .WB_dest        (WB_dest),
    .ID_allowin     (ID_allowin),
    .br_signal      (br_signal),
    .EXsignal_valid (EXsignal_valid),
    .EX_signal      (EX_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    WB_rf_bus = {1'b1, addr, data};
    @(posedge clk); #1;
    WB_rf_bus = '0;
  endtask

  // Presents one instruction; on return it sits in ID and outputs are settled.
  task automatic load(input logic [31:0] inst, input logic [31:0] pc);
    IDsignal_valid = 1'b1;
    ID_signal = {inst, pc};
    @(posedge clk); #1;
    IDsignal_valid = 1'b0;
    #1;
  endtask

  task automatic drain();
    EX_allowin = 1'b1;
    EX_dest = '0; MEM_dest = '0; WB_dest = '0;
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    IDsignal_valid = 1'b0; ID_signal = '0; EX_allowin = 1'b1; WB_rf_bus = '0;
    EX_dest = '0; MEM_dest = '0; WB_dest = '0;
    #2;
    tests_run++; if (ID_allowin !== 1'b1) begin tests_failed++; $display("FAIL reset_allowin: got %b exp 1", ID_allowin); end
    tests_run++; if (EXsignal_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_exvalid: got %b exp 0", EXsignal_valid); end
    tests_run++; if (br_signal !== 33'h0) begin tests_failed++; $display("FAIL reset_br: got %h exp 0", br_signal); end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    tests_run++; if (EXsignal_valid !== 1'b0) begin tests_failed++; $display("FAIL post_reset_exvalid: got %b exp 0", EXsignal_valid); end
  endtask

  task automatic test_beq();
    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd5);
    load(32'h58001022, 32'h1c000000);
    tests_run++; if (br_signal !== 33'h1_1c000010) begin tests_failed++; $display("FAIL beq_br: got %h exp %h", br_signal, 33'h1_1c000010); end
    tests_run++; if (EXsignal_valid !== 1'b1) begin tests_failed++; $display("FAIL beq_exvalid: got %b exp 1", EXsignal_valid); end
    tests_run++; if (EX_signal[34] !== 1'b0) begin tests_failed++; $display("FAIL beq_gr_we: got %b exp 0", EX_signal[34]); end
    drain();
    tests_run++; if (EXsignal_valid !== 1'b0) begin tests_failed++; $display("FAIL beq_drained: got %b exp 0", EXsignal_valid); end
    // bne r1,r2 with equal operands falls through
    load(32'h5c001022, 32'h1c000004);
    tests_run++; if (br_signal[32] !== 1'b0) begin tests_failed++; $display("FAIL bne_taken: got %b exp 0", br_signal[32]); end
    tests_run++; if (EXsignal_valid !== 1'b1) begin tests_failed++; $display("FAIL bne_exvalid: got %b exp 1", EXsignal_valid); end
    drain();
  endtask

  task automatic test_hazard();
    EX_dest = 5'd1;
    load(32'h00100823, 32'h1c000008);
    tests_run++; if (ID_allowin !== 1'b0) begin tests_failed++; $display("FAIL haz_allowin: got %b exp 0", ID_allowin); end
    tests_run++; if (EXsignal_valid !== 1'b0) begin tests_failed++; $display("FAIL haz_exvalid: got %b exp 0", EXsignal_valid); end
    tests_run++; if (br_signal[32] !== 1'b0) begin tests_failed++; $display("FAIL haz_br: got %b exp 0", br_signal[32]); end
    @(posedge clk); #1;
    EX_dest = 5'd0;
    #1;
    tests_run++; if (EXsignal_valid !== 1'b1) begin tests_failed++; $display("FAIL haz_release_valid: got %b exp 1", EXsignal_valid); end
    tests_run++; if (EX_signal[135:104] !== 32'd5) begin tests_failed++; $display("FAIL haz_src1: got %h exp 5", EX_signal[135:104]); end
    tests_run++; if (EX_signal[103:72] !== 32'd5) begin tests_failed++; $display("FAIL haz_src2: got %h exp 5", EX_signal[103:72]); end
    tests_run++; if (EX_signal[39:35] !== 5'd3) begin tests_failed++; $display("FAIL haz_dest: got %0d exp 3", EX_signal[39:35]); end
    tests_run++; if (EX_signal[147:136] !== 12'h001) begin tests_failed++; $display("FAIL haz_aluop: got %h exp 001", EX_signal[147:136]); end
    drain();
  endtask

  task automatic test_hazard_table();
    logic [31:0] insts [6];
    logic [14:0] dests [6];
    logic        stall [6];
    insts[0] = 32'h00100823; dests[0] = {5'd0, 5'd2, 5'd0};   stall[0] = 1'b1;
    insts[1] = 32'h00100823; dests[1] = {5'd0, 5'd0, 5'd1};   stall[1] = 1'b1;
    insts[2] = 32'h00100823; dests[2] = {5'd3, 5'd0, 5'd0};   stall[2] = 1'b0;
    insts[3] = 32'h29bff022; dests[3] = {5'd0, 5'd0, 5'd2};   stall[3] = 1'b1;
    insts[4] = 32'h02801401; dests[4] = {5'd5, 5'd0, 5'd0};   stall[4] = 1'b0;
    insts[5] = 32'hffffffff; dests[5] = {5'd31, 5'd31, 5'd31}; stall[5] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      {EX_dest, MEM_dest, WB_dest} = dests[i];
      load(insts[i], 32'h1c000200);
      tests_run++; if (EXsignal_valid !== !stall[i]) begin tests_failed++; $display("FAIL haztab%0d_valid: got %b exp %b", i, EXsignal_valid, !stall[i]); end
      tests_run++; if (ID_allowin !== !stall[i]) begin tests_failed++; $display("FAIL haztab%0d_allowin: got %b exp %b", i, ID_allowin, !stall[i]); end
      drain();
    end
  endtask

  task automatic test_stall();
    EX_allowin = 1'b0;
    load(32'h02801401, 32'h1c00000c);
    // A second instruction offered during the stall must not be taken.
    IDsignal_valid = 1'b1;
    ID_signal = {32'h02801c02, 32'h1c000010};
    for (int c = 0; c < 3; c++) begin
      tests_run++; if (ID_allowin !== 1'b0) begin tests_failed++; $display("FAIL stall%0d_allowin: got %b exp 0", c, ID_allowin); end
      tests_run++; if (EXsignal_valid !== 1'b1) begin tests_failed++; $display("FAIL stall%0d_valid: got %b exp 1", c, EXsignal_valid); end
      tests_run++; if (EX_signal[103:72] !== 32'd5 || EX_signal[39:35] !== 5'd1 || EX_signal[31:0] !== 32'h1c00000c) begin
        tests_failed++; $display("FAIL stall%0d_hold: got src2=%h dest=%0d pc=%h exp 5/1/1c00000c", c, EX_signal[103:72], EX_signal[39:35], EX_signal[31:0]);
      end
      @(posedge clk); #2;
    end
    IDsignal_valid = 1'b0;
    EX_allowin = 1'b1;
    #1;
    tests_run++; if (ID_allowin !== 1'b1) begin tests_failed++; $display("FAIL stall_release_allowin: got %b exp 1", ID_allowin); end
    tests_run++; if (EX_signal[135:104] !== 32'd0 || EX_signal[34] !== 1'b1) begin tests_failed++; $display("FAIL stall_release_fields: got src1=%h gr_we=%b exp 0/1", EX_signal[135:104], EX_signal[34]); end
    @(posedge clk); #2;
    tests_run++; if (EXsignal_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_single_issue: got %b exp 0", EXsignal_valid); end
  endtask

  task automatic test_jumps();
    load(32'h54000400, 32'h1c000100);
    tests_run++; if (br_signal !== 33'h1_1c000104) begin tests_failed++; $display("FAIL bl_br: got %h exp %h", br_signal, 33'h1_1c000104); end
    tests_run++; if (EX_signal[39:35] !== 5'd1 || EX_signal[34] !== 1'b1) begin tests_failed++; $display("FAIL bl_dest: got %0d/%b exp 1/1", EX_signal[39:35], EX_signal[34]); end
    tests_run++; if (EX_signal[135:104] !== 32'h1c000100) begin tests_failed++; $display("FAIL bl_src1: got %h exp 1c000100", EX_signal[135:104]); end
    tests_run++; if (EX_signal[103:72] !== 32'd4) begin tests_failed++; $display("FAIL bl_src2: got %h exp 4", EX_signal[103:72]); end
    drain();
    // jirl r1, r2, 1 -> target r2 + 4
    load(32'h4c000441, 32'h1c000120);
    tests_run++; if (br_signal !== 33'h1_00000009) begin tests_failed++; $display("FAIL jirl_br: got %h exp %h", br_signal, 33'h1_00000009); end
    tests_run++; if (EX_signal[135:104] !== 32'h1c000120) begin tests_failed++; $display("FAIL jirl_src1: got %h exp 1c000120", EX_signal[135:104]); end
    drain();
    // b with negative offs26 = -1
    load(32'h53ffffff, 32'h1c000200);
    tests_run++; if (br_signal !== 33'h1_1c0001fc) begin tests_failed++; $display("FAIL b_neg_br: got %h exp %h", br_signal, 33'h1_1c0001fc); end
    tests_run++; if (EX_signal[34] !== 1'b0) begin tests_failed++; $display("FAIL b_gr_we: got %b exp 0", EX_signal[34]); end
    drain();
  endtask

  task automatic test_imm();
    load(32'h15000024, 32'h1c000300);
    tests_run++; if (EX_signal[103:72] !== 32'h80001000) begin tests_failed++; $display("FAIL lu12i_src2: got %h exp 80001000", EX_signal[103:72]); end
    tests_run++; if (EX_signal[147:136] !== 12'h800) begin tests_failed++; $display("FAIL lu12i_aluop: got %h exp 800", EX_signal[147:136]); end
    drain();
    load(32'h29bff022, 32'h1c000304);
    tests_run++; if (EX_signal[103:72] !== 32'hfffffffc) begin tests_failed++; $display("FAIL st_src2: got %h exp fffffffc", EX_signal[103:72]); end
    tests_run++; if (EX_signal[71:40] !== 32'd5) begin tests_failed++; $display("FAIL st_rkd: got %h exp 5", EX_signal[71:40]); end
    tests_run++; if (EX_signal[34:32] !== 3'b010) begin tests_failed++; $display("FAIL st_ctl: got %b exp 010", EX_signal[34:32]); end
    drain();
    load(32'h0040fc26, 32'h1c000308);
    tests_run++; if (EX_signal[103:72] !== 32'd31 || EX_signal[147:136] !== 12'h100) begin tests_failed++; $display("FAIL slli_fields: got src2=%h alu=%h exp 1f/100", EX_signal[103:72], EX_signal[147:136]); end
    drain();
    load(32'h00100820, 32'h1c00030c);
    tests_run++; if (EX_signal[34] !== 1'b0) begin tests_failed++; $display("FAIL r0_dest_gr_we: got %b exp 0", EX_signal[34]); end
    drain();
  endtask

  task automatic test_illegal();
    load(32'hffffffff, 32'h1c000400);
    tests_run++; if (EXsignal_valid !== 1'b1) begin tests_failed++; $display("FAIL ill_valid: got %b exp 1", EXsignal_valid); end
    tests_run++; if (EX_signal[34:33] !== 2'b00) begin tests_failed++; $display("FAIL ill_we: got %b exp 00", EX_signal[34:33]); end
    tests_run++; if (br_signal[32] !== 1'b0) begin tests_failed++; $display("FAIL ill_br: got %b exp 0", br_signal[32]); end
    drain();
  endtask

  task automatic test_back_to_back();
    IDsignal_valid = 1'b1;
    ID_signal = {32'h02801401, 32'h1c000500};
    @(posedge clk); #1;
    ID_signal = {32'h02801c02, 32'h1c000504};
    #1;
    tests_run++; if (EXsignal_valid !== 1'b1 || EX_signal[103:72] !== 32'd5 || EX_signal[39:35] !== 5'd1) begin
      tests_failed++; $display("FAIL b2b_first: got v=%b src2=%h dest=%0d exp 1/5/1", EXsignal_valid, EX_signal[103:72], EX_signal[39:35]);
    end
    @(posedge clk); #1;
    IDsignal_valid = 1'b0;
    #1;
    tests_run++; if (EXsignal_valid !== 1'b1 || EX_signal[103:72] !== 32'd7 || EX_signal[39:35] !== 5'd2) begin
      tests_failed++; $display("FAIL b2b_second: got v=%b src2=%h dest=%0d exp 1/7/2", EXsignal_valid, EX_signal[103:72], EX_signal[39:35]);
    end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    EX_allowin = 1'b0;
    load(32'h02801401, 32'h1c000600);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    tests_run++; if (EXsignal_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_stall_valid: got %b exp 0", EXsignal_valid); end
    tests_run++; if (ID_allowin !== 1'b1) begin tests_failed++; $display("FAIL rst_stall_allowin: got %b exp 1", ID_allowin); end
    tests_run++; if (br_signal !== 33'h0) begin tests_failed++; $display("FAIL rst_stall_br: got %h exp 0", br_signal); end
    @(posedge clk); #1;
    reset = 1'b0;
    EX_allowin = 1'b1;
    // Register contents survive reset
    load(32'h00100823, 32'h1c000604);
    tests_run++; if (EX_signal[135:104] !== 32'd5 || EX_signal[103:72] !== 32'd5) begin
      tests_failed++; $display("FAIL rf_after_reset: got %h/%h exp 5/5", EX_signal[135:104], EX_signal[103:72]);
    end
    drain();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_beq();
    test_hazard();
    test_hazard_table();
    test_stall();
    test_jumps();
    test_imm();
    test_illegal();
    test_back_to_back();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, rising edge.
REQ-002 SHALL have reset  input  1  asynchronous, active-high.
REQ-003 SHALL have IDsignal_valid  input  1  IF->ID bundle valid.
REQ-004 SHALL have ID_signal  input  64  {inst[63:32], pc[31:0]} from IF.
REQ-005 SHALL have EX_allowin  input  1  EX can accept this cycle.
REQ-006 SHALL have WB_rf_bus  input  38  {we[37], waddr[36:32], wdata[31:0]} regfile write.
REQ-007 SHALL have EX_dest, MEM_dest, WB_dest  input  5 each  pending dest reg (0 = none).
REQ-008 SHALL have ID_allowin  output  1  ID can accept.
REQ-009 SHALL have br_signal  output  33  {br_taken[32], br_target[31:0]} to IF.
REQ-010 SHALL have EXsignal_valid  output  1  ID->EX bundle valid.
REQ-011 SHALL have EX_signal  output  148  {alu_op[147:136], src1[135:104], src2[103:72], rkd_value[71:40], dest[39:35], gr_we[34], mem_we[33], res_from_mem[32], pc[31:0]}.

Function
REQ-012 SHALL hold ID_valid and ID_signal register; on ID_allowin load ID_valid<=IDsignal_valid and, when IDsignal_valid, the bundle.
REQ-013 SHALL compute ID_readygo = !(ID_valid && hazard); ID_allowin = !ID_valid || (ID_readygo && EX_allowin); EXsignal_valid = ID_valid && ID_readygo.
REQ-014 SHALL flag hazard when a read source (rj, rk or rd per decode, excluding r0) equals a nonzero EX_dest, MEM_dest or WB_dest; no forwarding.
REQ-015 SHALL decode LA32R subset: add.w, sub.w, slt, sltu, nor, and, or, xor, slli.w, srli.w, srai.w, addi.w, lu12i.w, ld.w, st.w, jirl, b, bl, beq, bne; any other encoding SHALL drive gr_we=0, mem_we=0 (nop).
REQ-016 SHALL sign-extend si12, offs16<<2, offs26<<2; zero-extend ui5; lu12i.w immediate = {si20, 12'b0}.
REQ-017 SHALL set src1 = pc for bl/jirl, else rj value; src2 = 4 for bl/jirl, immediate for I-type, else rk value; rkd_value = rd value (st.w data).
REQ-018 SHALL set dest = r1 for bl, rd otherwise; gr_we = 0 for st.w, b, beq, bne; a dest of r0 SHALL clear gr_we.
REQ-019 SHALL assert br_taken combinationally only when ID_valid && ID_readygo and: b, bl, jirl, beq with rj==rd, or bne with rj!=rd.
REQ-020 SHALL set br_target = pc+offs for b/bl/beq/bne, rj+offs16<<2 for jirl; br_target is don't-care when br_taken=0.
REQ-021 SHALL read regfile asynchronously; a same-cycle WB write to a read address SHALL NOT bypass (hazard covers it).
REQ-022 SHALL keep EX_signal stable while EX_allowin=0 and EXsignal_valid=1.

Reset
REQ-023 SHALL on reset clear ID_valid to 0 and ID_signal register to 0 immediately (async).
REQ-024 SHALL drive, under reset: ID_allowin=1, EXsignal_valid=0, br_signal=0.
REQ-025 SHALL NOT reset regfile contents, except r0 reads always 0.

Structure
REQ-026 SHALL place alu_op one-hot bit indices, bundle widths (64, 148, 38, 33) and opcode constants in shared package pipe_pkg.
REQ-027 SHALL instantiate one sub-module regfile: 32x32, two async read ports, one sync write port, r0 hardwired 0.

Verification
REQ-028 SHALL cover: WB writes r1=5, r2=5; ID gets beq r1,r2,+16 (0x58001022) pc=0x1c000000 -> br_signal=33'h1_1c000010 same cycle, EXsignal_valid=1.
REQ-029 SHALL cover: add.w r3,r1,r2 (0x00100823) with EX_dest=1 -> ID_allowin=0, EXsignal_valid=0, br_taken=0; EX_dest=0 next cycle -> issues with src1=5, src2=5, dest=3.
REQ-030 SHALL cover: addi.w r1,r0,5 (0x02801401) with EX_allowin=0 for 3 cycles -> EX_signal held, ID_allowin=0; release -> single issue.
REQ-031 SHALL cover: bl offs26=1 at pc=0x1c000100 -> br_target=0x1c000104, dest=1, src1=0x1c000100, src2=4, gr_we=1.
REQ-032 SHALL cover: reset asserted mid-stall -> EXsignal_valid=0, ID_allowin=1 before next clock edge.
REQ-033 SHALL cover: illegal inst 0xffffffff -> EXsignal_valid=1 with gr_we=0, mem_we=0, br_taken=0.
